keypad_scan_fifo: RTL and testbench
===================================

// Module: keypad_scan_fifo
// PURPOSE
//  Parametrised matrix-keypad scanner: walks ROWS row lines one at a time and samples COLS column inputs.
//  Debounces every key independently and queues press (optionally release) events in a FIFO.
//  The FIFO is read through a valid/ready port; fsm_module consumes it in place of its inline keypad scan.
//  Generalises the fixed 4x4 scan to any matrix size, and adds multi-key rollover and event buffering.
// PARAMETERS
//  ROWS           4     row outputs driven (>=2)
//  COLS           4     column inputs sampled (>=1)
//  SCAN_DIV       6000  clk cycles per row slot (1 ms at 6 MHz); must be >= COLS+2
//  DEBOUNCE_SCANS 8     consecutive identical frame samples needed to change a key's debounced state (1..255)
//  FIFO_DEPTH     8     event FIFO entries (power of 2, >=2)
//  REPORT_RELEASE 0     1 = also queue release events
//  KW = $clog2(ROWS*COLS) key-code width (localparam)
// PORTS
//  clk          in   1    system clock
//  rstn         in   1    asynchronous active-low reset
//  row_out      out  ROWS active-low row drive: exactly one bit low at any time
//  col_in       in   COLS column inputs, externally pulled up; low = key pressed; two-flop synchronised inside
//  key_valid    out  1    FIFO head holds an event
//  key_ready    in   1    consumer accepts the head when valid&ready at a clk edge
//  key_code     out  KW   head event code = row*COLS + col
//  key_release  out  1    head event is a release (always 0 when REPORT_RELEASE=0)
//  key_down     out  ROWS*COLS debounced state of every key, 1 = pressed
//  overflow     out  1    one-cycle pulse when an event is dropped because the FIFO is full
// BEHAVIOUR
//  Reset values: row_out=~1 (row 0 low); slot counter 0; key_down=0; all debounce counters 0; FIFO empty.
//   So key_valid=0, key_code=0, key_release=0, overflow=0.
//  Scan: slot counter counts 0..SCAN_DIV-1 and wraps. On wrap the active row advances r -> (r+1) mod ROWS.
//   row_out changes on the clk edge where the counter returns to 0.
//  Sample: at count SCAN_DIV-COLS-1, latch ~col_sync as the raw state of the COLS keys in the active row.
//   This leaves settle time plus the 2-flop synchroniser delay.
//  Update phase: on the COLS cycles after the sample, process one key per cycle, col 0 first.
//   raw==key_down: clear that key's counter.
//   raw!=key_down: increment the counter. On reaching DEBOUNCE_SCANS, toggle key_down, clear the counter and generate an event.
//   Event generation: presses always; releases only if REPORT_RELEASE=1.
//  Event order is therefore deterministic: frame order, then row order, then col ascending.
//   Any number of simultaneously held keys is tracked (full rollover).
//  FIFO: at most one push and one pop per cycle. Push latency: the event is visible at key_valid 1 clk after its update cycle.
//   Pop on key_valid&key_ready. The head outputs stay stable while valid&!ready.
//  Full FIFO: a push succeeds only if a pop happens in the same cycle; otherwise the event is dropped.
//   On a drop, overflow pulses 1 cycle and key_down still updates.
//  Empty FIFO: key_ready is ignored; key_valid=0, and key_code/key_release hold their last values.
//  Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty are decided by MSB compare.
//  Reset asserted mid-scan or mid-update: everything returns to reset values immediately; no partial event is queued.
//  No combinational path from key_ready to key_valid. key_down is registered.
// TESTING (bench params: ROWS=4 COLS=4 SCAN_DIV=8 DEBOUNCE_SCANS=2 FIFO_DEPTH=4)
//  1 Reset, idle cols all 1: row_out cycles 1110,1101,1011,0111, each for 8 clks; key_valid stays 0 for 10 frames.
//  2 Hold key (r2,c1) low while row 2 is active, from frame 0 on:
//    key_valid rises after the 2nd frame sample with key_code=9, key_release=0, and key_down[9]=1.
//    Exactly one event is produced.
//  3 Bounce: press (r0,c3) for 1 frame, release 1 frame, repeat 5x -> no event, key_down[3]=0.
//  4 REPORT_RELEASE=1: press key 5 for 4 frames, then release.
//    Events read in order: (5,0) then (5,1); with key_ready=1 each pops in 1 clk.
//  5 Rollover: hold keys 0,1,2,3 together (same row) with key_ready=0.
//    FIFO receives 0,1,2,3 in that order and key_valid=1.
//    A 5th key (4) press gives one overflow pulse, and key_down[4]=1.
//  6 Assert rstn=0 for 1 clk mid-update with FIFO holding 2 events:
//    Next cycle key_valid=0, key_down=0 and row_out=1110.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: one active-low row per slot, per-key debounce with full rollover,
// and a valid/ready event FIFO of key presses (and optionally releases).
module keypad_scan_fifo #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 6000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter bit REPORT_RELEASE = 1'b0,
  localparam int KW            = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic [ROWS-1:0]      row_out,
  input  logic [COLS-1:0]      col_in,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [KW-1:0]        key_code,
  output logic                 key_release,
  output logic [ROWS*COLS-1:0] key_down,
  output logic                 overflow
);
  localparam int NK  = ROWS * COLS;
  localparam int CW  = $clog2(SCAN_DIV);
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SCAN_DIV - COLS - 1);
  localparam logic [CW-1:0] UPD_FIRST = CW'(SCAN_DIV - COLS);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

  logic [COLS-1:0] sync1_q, sync2_q, raw_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   row_q, row_d;
  logic [ROWS-1:0] row_out_q;
  logic [NK-1:0]   down_q;
  logic [DW-1:0]   dcnt_q [NK];
  logic [KW-1:0]   mem_code_q [FIFO_DEPTH];
  logic            mem_rel_q  [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic            ovf_q;

  logic            upd_s, toggle_s, push_s, empty_s, full_s, pop_s, wr_s, drop_s;
  logic [CLW-1:0]  col_s;
  logic [KW-1:0]   key_s;
  logic [DW-1:0]   dcnt_d;
  logic [AW-1:0]   head_s;

  // Per-key debounce decision for the key addressed by the current update slot.
  always_comb begin
    upd_s    = (cnt_q >= UPD_FIRST);
    col_s    = CLW'(cnt_q - UPD_FIRST);
    key_s    = KW'(row_q) * KW'(COLS) + KW'(col_s);
    toggle_s = 1'b0;
    dcnt_d   = '0;
    if (upd_s && (raw_q[col_s] != down_q[key_s])) begin
      if ((dcnt_q[key_s] + DW'(1)) == DW'(DEBOUNCE_SCANS)) begin
        toggle_s = 1'b1;
      end else begin
        dcnt_d = dcnt_q[key_s] + DW'(1);
      end
    end else begin
      dcnt_d = '0;
    end
    push_s = toggle_s && (!down_q[key_s] || REPORT_RELEASE);
  end

  // FIFO bookkeeping; a push into a full FIFO only lands when a pop frees a slot the same cycle.
  always_comb begin
    empty_s = (wptr_q == rptr_q);
    full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_s   = !empty_s && key_ready;
    wr_s    = push_s && (!full_s || pop_s);
    drop_s  = push_s && !wr_s;
    head_s  = empty_s ? (rptr_q[AW-1:0] - AW'(1)) : rptr_q[AW-1:0];
  end

  always_comb row_d = (row_q == RW'(ROWS - 1)) ? '0 : (row_q + RW'(1));

  // Column synchroniser, slot counter, row walker and raw-sample latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      cnt_q     <= '0;
      row_q     <= '0;
      row_out_q <= ~ROWS'(1);
      raw_q     <= '0;
    end else begin
      sync1_q <= col_in;
      sync2_q <= sync1_q;
      if (cnt_q == SAMPLE_AT) raw_q <= ~sync2_q;
      if (cnt_q == SLOT_LAST) begin
        cnt_q     <= '0;
        row_q     <= row_d;
        row_out_q <= ~(ROWS'(1) << row_d);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Debounced key state and per-key counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      down_q <= '0;
      for (int i = 0; i < NK; i++) dcnt_q[i] <= '0;
    end else if (upd_s) begin
      if (toggle_s) down_q[key_s] <= ~down_q[key_s];
      dcnt_q[key_s] <= dcnt_d;
    end
  end

  // Event storage and read/write pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_code_q[i] <= '0;
        mem_rel_q[i]  <= 1'b0;
      end
    end else begin
      if (wr_s) begin
        mem_code_q[wptr_q[AW-1:0]] <= key_s;
        mem_rel_q[wptr_q[AW-1:0]]  <= down_q[key_s];
        wptr_q                     <= wptr_q + PW'(1);
      end
      if (pop_s) rptr_q <= rptr_q + PW'(1);
      ovf_q <= drop_s;
    end
  end

  // When empty, the head points at the slot just popped, so code/release hold their last values.
  assign row_out     = row_out_q;
  assign key_valid   = !empty_s;
  assign key_code    = mem_code_q[head_s];
  assign key_release = mem_rel_q[head_s];
  assign key_down    = down_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Randomised scoreboard bench for keypad_scan_fifo: a keypad model drives the columns,
// a frame-level reference model predicts events, and a negedge monitor compares.
module tb_keypad_scan_fifo;
  localparam int ROWS = 4, COLS = 4, SD = 8, DB = 2, DEPTH = 4, NK = 16, KW = 4;
  localparam bit RR = 1'b1;

  typedef struct packed { logic [KW-1:0] code; logic rel; } ev_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_in;
  logic            key_valid, key_ready = 1'b0, key_release, overflow;
  logic [KW-1:0]   key_code;
  logic [NK-1:0]   key_down;
  logic [NK-1:0]   pressed = '0;
  bit              rand_ready = 1'b0;

  int n_checks = 0, n_fail = 0;
  int n_pop_seen = 0, n_ovf_seen = 0, n_valid_seen = 0;

  int            m_cnt, m_row;
  bit [NK-1:0]   m_state;
  int            m_dcnt [NK];
  bit [COLS-1:0] m_raw;
  ev_t           exp_q [$];
  bit            exp_ovf;
  logic [KW-1:0] last_code;
  logic          last_rel;

  keypad_scan_fifo #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DB),
                     .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(RR)) dut (
    .clk(clk), .rstn(rstn), .row_out(row_out), .col_in(col_in),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_release(key_release), .key_down(key_down), .overflow(overflow));

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its column low while its row is driven low.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_out[r] && pressed[r*COLS+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_row = 0; m_state = '0; m_raw = '0; exp_ovf = 1'b0;
    for (int i = 0; i < NK; i++) m_dcnt[i] = 0;
    exp_q.delete();
    last_code = '0; last_rel = 1'b0;
  endtask

  // One clock of the scan schedule: m_cnt is the slot that is ending.
  task automatic model_step();
    int c, k;
    ev_t e;
    exp_ovf = 1'b0;
    if (m_cnt >= SD - COLS) begin
      c = m_cnt - (SD - COLS);
      k = m_row * COLS + c;
      if (m_raw[c] == m_state[k]) m_dcnt[k] = 0;
      else begin
        m_dcnt[k]++;
        if (m_dcnt[k] == DB) begin
          m_state[k] = ~m_state[k];
          m_dcnt[k] = 0;
          if (m_state[k] || RR) begin
            e.code = KW'(k);
            e.rel  = ~m_state[k];
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else exp_ovf = 1'b1;
          end
        end
      end
    end
    if (m_cnt == SD - COLS - 1)
      for (int j = 0; j < COLS; j++) m_raw[j] = pressed[m_row*COLS+j];
    m_cnt++;
    if (m_cnt == SD) begin
      m_cnt = 0;
      m_row = (m_row + 1) % ROWS;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // Monitor: compares every DUT output against the model and retires popped events.
  initial begin
    logic [ROWS-1:0] exp_row;
    forever begin
      @(negedge clk);
      exp_row = ~(ROWS'(1) << m_row);
      check("row_out", 32'(row_out), 32'(exp_row));
      check("key_down", 32'(key_down), 32'(m_state));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("key_valid", 32'(key_valid), 32'(exp_q.size() != 0));
      if (overflow === 1'b1) n_ovf_seen++;
      if (key_valid === 1'b1) n_valid_seen++;
      if (exp_q.size() != 0) begin
        check("key_code", 32'(key_code), 32'(exp_q[0].code));
        check("key_release", 32'(key_release), 32'(exp_q[0].rel));
        if (key_ready && rstn) begin
          last_code = exp_q[0].code;
          last_rel  = exp_q[0].rel;
          void'(exp_q.pop_front());
          if (key_valid === 1'b1) n_pop_seen++;
        end
      end else begin
        check("hold_code", 32'(key_code), 32'(last_code));
        check("hold_release", 32'(key_release), 32'(last_rel));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) key_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frames(input int n);
    cycles(n * ROWS * SD);
  endtask

  task automatic wait_frame();
    bit found = 1'b0;
    for (int i = 0; i < 4 * ROWS * SD && !found; i++) begin
      @(posedge clk); #1;
      if (m_cnt == 0 && m_row == 0) found = 1'b1;
    end
    check("frame_sync_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    int base_pop, base_ovf, base_valid;
    bit found;
    cycles(3);
    check("reset_row_out", 32'(row_out), 32'hE);
    check("reset_valid", 32'(key_valid), 32'd0);
    rstn = 1'b1;

    // Idle columns: rows cycle, no events.
    base_valid = n_valid_seen;
    wait_frame();
    frames(10);
    check("idle_no_valid", 32'(n_valid_seen - base_valid), 32'd0);

    // Single held key (row 2, col 1) -> one press event with code 9.
    pressed = 16'h0200;
    frames(3);
    check("k9_valid", 32'(key_valid), 32'd1);
    check("k9_code", 32'(key_code), 32'd9);
    check("k9_down", 32'(key_down[9]), 32'd1);
    base_pop = n_pop_seen;
    key_ready = 1'b1;
    frames(1);
    check("k9_one_event", 32'(n_pop_seen - base_pop), 32'd1);
    pressed = '0;
    frames(3);

    // Bounce on key 3: alternating frames never debounce.
    base_valid = n_valid_seen;
    for (int i = 0; i < 5; i++) begin
      pressed = 16'h0008; frames(1);
      pressed = '0;       frames(1);
    end
    check("bounce_no_event", 32'(n_valid_seen - base_valid), 32'd0);
    check("bounce_down3", 32'(key_down[3]), 32'd0);

    // Key 5 press then release: two events, each popped in one clock.
    base_pop = n_pop_seen;
    pressed = 16'h0020; frames(4);
    pressed = '0;       frames(4);
    check("k5_two_events", 32'(n_pop_seen - base_pop), 32'd2);

    // Rollover with a stalled consumer: keys 0..3 fill the FIFO, key 4 overflows.
    key_ready = 1'b0;
    base_ovf = n_ovf_seen;
    pressed = 16'h000F; frames(3);
    pressed = 16'h001F; frames(3);
    check("roll_overflow_once", 32'(n_ovf_seen - base_ovf), 32'd1);
    check("roll_down4", 32'(key_down[4]), 32'd1);
    check("roll_head0", 32'(key_code), 32'd0);
    key_ready = 1'b1;
    pressed = '0;
    frames(4);

    // Random keys and random consumer.
    rand_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      pressed = NK'($urandom & $urandom & $urandom);
      frames(1 + int'($urandom_range(0, 2)));
    end
    pressed = '0;
    frames(4);
    rand_ready = 1'b0;
    cycles(1);
    key_ready = 1'b1;
    frames(3);

    // Reset mid-update with two events queued.
    key_ready = 1'b0;
    pressed = 16'h20C0;
    frames(1);
    found = 1'b0;
    for (int i = 0; i < 2 * ROWS * SD && !found; i++) begin
      @(posedge clk); #1;
      if (m_row == 3 && m_cnt == SD - COLS + 1) found = 1'b1;
    end
    check("midupd_sync_timeout", 32'(found), 32'd1);
    check("pre_reset_valid", 32'(key_valid), 32'd1);
    rstn = 1'b0;
    pressed = '0;
    #1;
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_down", 32'(key_down), 32'd0);
    check("rst_row_out", 32'(row_out), 32'hE);
    @(posedge clk); #1;
    rstn = 1'b1;
    key_ready = 1'b1;
    frames(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
